mod_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/mod_counter.sv | 96 +++++++++
 tb/tb_mod_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter and its prescaler.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned DEF_WIDTH     = 6;
  localparam int unsigned DEF_MAX_COUNT = 63;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles into one tick per PRESCALE cycles; phase holds while en=0.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned PW = (clog2(PRESCALE) == 0) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_prescaler: PRESCALE must be >= 1");
  end

  logic [PW-1:0] phase;

  assign tick = en & ~sync_clr & (phase == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (sync_clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down counter with prescale, wrap/saturate, load, compare and sticky boundary flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
  parameter int unsigned PRESCALE  = 1,
  parameter bit          SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  if (64'(MAX_COUNT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("mod_counter: MAX_COUNT does not fit in WIDTH bits");
  end

  logic             tick;
  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_clamped;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign at_max       = (count == MAX_V);
  assign at_zero      = (count == '0);
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  assign match        = (count == cmp_val);

  // Bounds are tested before stepping, so the arithmetic never leaves 0..MAX_COUNT.
  always_comb begin
    count_nxt = count;
    boundary  = 1'b0;
    if (tick) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : MAX_V;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      ovf   <= ovf & ~ovf_clr;
    end else begin
      count <= count_nxt;
      tc    <= boundary;
      ovf   <= boundary | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: three mod_counter configurations on shared stimulus, scoreboard-compared.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, clr, en, up_dn, load, ovf_clr;
  logic [5:0] load_val, cmp_val;

  logic [5:0] cnt0, cnt2;
  logic [3:0] cnt1;
  logic       tc0, tc1, tc2, m0, m1, m2, ov0, ov1, ov2;

  always #5 clk = ~clk;

  mod_counter u_def (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .ovf_clr(ovf_clr),
    .count(cnt0), .tc(tc0), .match(m0), .ovf(ov0)
  );

  mod_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]), .ovf_clr(ovf_clr),
    .count(cnt1), .tc(tc1), .match(m1), .ovf(ov1)
  );

  mod_counter #(.PRESCALE(4)) u_ps4 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .ovf_clr(ovf_clr),
    .count(cnt2), .tc(tc2), .match(m2), .ovf(ov2)
  );

  typedef struct {
    string      name;
    int         inst;
    logic [5:0] cnt;
    logic       tc;
    logic       m;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       clr, en, up, ld;
    logic [5:0] lv, cmp;
    logic       oc;
    logic [5:0] cnt;
    logic       tc, m, ovf;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_out(input exp_t e);
    logic [5:0] ac;
    logic       at, am, ao;
    case (e.inst)
      0:       begin ac = cnt0;          at = tc0; am = m0; ao = ov0; end
      1:       begin ac = {2'b00, cnt1}; at = tc1; am = m1; ao = ov1; end
      default: begin ac = cnt2;          at = tc2; am = m2; ao = ov2; end
    endcase
    n_vec++;
    if ({ac, at, am, ao} !== {e.cnt, e.tc, e.m, e.ovf}) begin
      n_err++;
      $display("FAIL %s (inst %0d) t=%0t: got count=%0d tc=%b match=%b ovf=%b, required count=%0d tc=%b match=%b ovf=%b",
               e.name, e.inst, $time, ac, at, am, ao, e.cnt, e.tc, e.m, e.ovf);
    end
  endtask

  function automatic exp_t mk(input int inst, input string name, input int c,
                              input logic t, input logic m, input logic o);
    exp_t e;
    e.name = name; e.inst = inst; e.cnt = 6'(c); e.tc = t; e.m = m; e.ovf = o;
    return e;
  endfunction

  task automatic set_in(input logic c, input logic e, input logic u, input logic l,
                        input int lv, input int cmp, input logic oc);
    clr = c; en = e; up_dn = u; load = l;
    load_val = 6'(lv); cmp_val = 6'(cmp); ovf_clr = oc;
  endtask

  // Push the expectation for the coming edge, advance, then pop and compare.
  task automatic cyc(input int inst, input string name, input int c,
                     input logic t, input logic m, input logic o);
    exp_t e;
    sb.push_back(mk(inst, name, c, t, m, o));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask

  vec_t vt[19];

  initial begin
    //          clr en up ld  lv  cmp oc   cnt tc m ovf
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd1,  1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd2,  1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd3,  1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd4,  1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd5,  1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd6,  1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd62, 6'd5,  1'b0, 6'd62, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd63, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd0,  1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd1,  1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0, 6'd1,  1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd5,  1'b1, 6'd1,  1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd63, 6'd5,  1'b0, 6'd63, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b1, 6'd0,  1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 6'd63, 1'b1, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 6'd62, 1'b0, 1'b0, 1'b1};
    vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd62, 1'b0, 6'd62, 1'b0, 1'b1, 1'b1};
    vt[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd10, 6'd62, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
    #1;
    check_out(mk(0, "reset_def", 0, 1'b0, 1'b0, 1'b0));
    check_out(mk(1, "reset_sat", 0, 1'b0, 1'b0, 1'b0));
    check_out(mk(2, "reset_ps4", 0, 1'b0, 1'b0, 1'b0));
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Default config: wrap, load, match, sticky ovf, clr priority.
    foreach (vt[i]) begin
      set_in(vt[i].clr, vt[i].en, vt[i].up, vt[i].ld, int'(vt[i].lv), int'(vt[i].cmp), vt[i].oc);
      cyc(0, $sformatf("table[%0d]", i), int'(vt[i].cnt), vt[i].tc, vt[i].m, vt[i].ovf);
    end

    // Asynchronous reset between edges at count 17.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 0, 40, 1'b0);
    for (int i = 1; i <= 17; i++) cyc(0, "run_up", i, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out(mk(0, "async_rst_def", 0, 1'b0, 1'b0, 1'b0));
    check_out(mk(1, "async_rst_sat", 0, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b0;
    cyc(0, "resume_1", 1, 1'b0, 1'b0, 1'b0);
    cyc(0, "resume_2", 2, 1'b0, 1'b0, 1'b0);

    // Saturating MAX_COUNT=9 instance; cmp_val nibble 15 is beyond range.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 0, 15, 1'b0);
    cyc(1, "sat_clr", 0, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 2, 15, 1'b0);
    cyc(1, "sat_load2", 2, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1'b0);
    cyc(1, "sat_dn1", 1, 1'b0, 1'b0, 1'b0);
    cyc(1, "sat_dn0", 0, 1'b0, 1'b0, 1'b0);
    cyc(1, "sat_hold0a", 0, 1'b1, 1'b0, 1'b1);
    cyc(1, "sat_hold0b", 0, 1'b1, 1'b0, 1'b1);
    up_dn = 1'b1;
    cyc(1, "sat_up1", 1, 1'b0, 1'b0, 1'b1);
    cyc(1, "sat_up2", 2, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 12, 15, 1'b0);
    cyc(1, "sat_load_clamp", 9, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 0, 15, 1'b0);
    cyc(1, "sat_hold_max", 9, 1'b1, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 7, 15, 1'b0);
    cyc(1, "sat_load_tick", 7, 1'b0, 1'b0, 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 3, 15, 1'b0);
    cyc(1, "sat_clr_load", 0, 1'b0, 1'b0, 1'b0);

    // PRESCALE=4: step on every 4th enabled cycle, phase frozen while en=0.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 0, 40, 1'b0);
    cyc(2, "ps_clr", 0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    for (int i = 1; i <= 10; i++)
      cyc(2, $sformatf("ps_cyc%0d", i), i / 4, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    cyc(2, "ps_pause1", 2, 1'b0, 1'b0, 1'b0);
    cyc(2, "ps_pause2", 2, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    cyc(2, "ps_cyc13", 2, 1'b0, 1'b0, 1'b0);
    cyc(2, "ps_cyc14", 3, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
